// File: rtl/alu_pkg.sv
// Shared ALU control encodings and the multiply sequencer state type.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_BGE = 4'b1000;
  localparam logic [3:0] ALU_XOR = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier (low Data_Width bits of a*b) that borrows the shared
// ALU for every accumulate step through a req/gnt pair.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int Data_Width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [Data_Width-1:0] req_a,
  input  logic [Data_Width-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [Data_Width-1:0] rsp_data,
  output logic                  alu_req,
  input  logic                  alu_gnt,
  output logic [Data_Width-1:0] alu_op1,
  output logic [Data_Width-1:0] alu_op2,
  output logic [3:0]            alu_ctrl,
  input  logic [Data_Width-1:0] alu_out,
  output mul_state_t            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and a response transfer and a new
  // request acceptance never share an edge (ready is only high in IDLE).

  mul_state_t            state;
  logic [Data_Width-1:0] acc;
  logic [Data_Width-1:0] mcand;
  logic [Data_Width-1:0] mplier;
  logic [Data_Width-1:0] mplier_next;
  logic                  last_step;

  assign mplier_next = mplier >> 1;
  assign last_step   = (mplier_next == '0);

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == DONE);
    rsp_data  = acc;
    dbg_state = state;
    alu_req   = (state == STEP) && mplier[0];
    alu_op1   = '0;
    alu_op2   = '0;
    alu_ctrl  = ALU_ADD;
    if (alu_req) begin
      alu_op1 = acc;
      alu_op2 = mcand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            acc    <= '0;
            mcand  <= req_a;
            mplier <= req_b;
            state  <= STEP;
          end
        end
        STEP: begin
          if (mplier == '0) begin
            state <= DONE;
          end else if (mplier[0]) begin
            // Without a grant everything holds, so a stall costs exactly one cycle.
            if (alu_gnt) begin
              acc    <= alu_out;
              mcand  <= mcand << 1;
              mplier <= mplier_next;
              if (last_step) state <= DONE;
            end
          end else begin
            mcand  <= mcand << 1;
            mplier <= mplier_next;
            if (last_step) state <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed-vector bench for alu_mul_seq with a behavioural shared-ALU model.
module tb_alu_mul_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         alu_req;
  logic         alu_gnt = 1'b1;
  logic [W-1:0] alu_op1;
  logic [W-1:0] alu_op2;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_out;
  mul_state_t   dbg_state;

  int checks = 0;
  int errors = 0;

  alu_mul_seq #(.Data_Width(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_ctrl(alu_ctrl), .alu_out(alu_out), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Shared ALU: honours alu_ctrl, and returns junk when nobody asked for it.
  always_comb begin
    alu_out = 32'hDEAD_BEEF;
    if (alu_req) begin
      case (alu_ctrl)
        ALU_ADD: alu_out = alu_op1 + alu_op2;
        ALU_SUB: alu_out = alu_op1 - alu_op2;
        default: alu_out = alu_op1 ^ alu_op2;
      endcase
    end
  end

  // Present an operand pair; returns just after the accept edge (cycle T ends).
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output logic rdy);
    @(negedge clk);
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    rdy = req_ready;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Count cycles until rsp_valid (lat = n means cycle T+n), tracing alu_req.
  task automatic wait_rsp(output int lat, output logic [63:0] trace);
    lat = -1;
    trace = '0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      trace[n] = alu_req;
      if (rsp_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic take_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== '0) begin
      errors++;
      $display("FAIL reset_hs: req_ready=%b rsp_valid=%b rsp_data=%h, need 1 0 0",
               req_ready, rsp_valid, rsp_data);
    end
    checks++;
    if (alu_req !== 1'b0 || alu_op1 !== '0 || alu_op2 !== '0 || alu_ctrl !== 4'b0000) begin
      errors++;
      $display("FAIL reset_alu: req=%b op1=%h op2=%h ctrl=%b, need all 0",
               alu_req, alu_op1, alu_op2, alu_ctrl);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d need %0d", dbg_state, IDLE);
    end
    rst = 1'b0;
  endtask

  task automatic test_mul_basic();
    logic rdy;
    int lat;
    logic [63:0] tr;
    alu_gnt = 1'b1;
    send(32'd6, 32'd7, rdy);
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL basic_accept: req_ready=%b need 1", rdy);
    end
    wait_rsp(lat, tr);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL basic_latency: got %0d need 4", lat);
    end
    checks++;
    if (rsp_data !== 32'd42) begin
      errors++;
      $display("FAIL basic_data: got %h need %h", rsp_data, 32'd42);
    end
    checks++;
    if (tr[4:1] !== 4'b0111) begin
      errors++;
      $display("FAIL basic_alu_req: trace[4:1]=%b need 0111", tr[4:1]);
    end
    take_rsp();
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_return: req_ready=%b rsp_valid=%b need 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_zero_b();
    logic rdy;
    int lat;
    logic [63:0] tr;
    send(32'h1234_5678, 32'd0, rdy);
    wait_rsp(lat, tr);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL zero_latency: got %0d need 2", lat);
    end
    checks++;
    if (rsp_data !== 32'd0 || tr[2:1] !== 2'b00) begin
      errors++;
      $display("FAIL zero_data: data=%h alu_req trace=%b need 0 and 00", rsp_data, tr[2:1]);
    end
    take_rsp();
  endtask

  task automatic test_all_ones();
    logic rdy;
    int lat;
    logic [63:0] tr;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, rdy);
    wait_rsp(lat, tr);
    checks++;
    if (lat != 33) begin
      errors++;
      $display("FAIL ones_latency: got %0d need 33", lat);
    end
    checks++;
    if (rsp_data !== 32'h0000_0001) begin
      errors++;
      $display("FAIL ones_data: got %h need 00000001", rsp_data);
    end
    take_rsp();
  endtask

  task automatic test_negative();
    logic rdy;
    int lat;
    logic [63:0] tr;
    send(32'hFFFF_FFFD, 32'd5, rdy);
    wait_rsp(lat, tr);
    checks++;
    if (lat != 4 || rsp_data !== 32'hFFFF_FFF1) begin
      errors++;
      $display("FAIL neg_result: lat=%0d data=%h need 4 FFFFFFF1", lat, rsp_data);
    end
    checks++;
    if (tr[3:1] !== 3'b101) begin
      errors++;
      $display("FAIL neg_alu_req: trace[3:1]=%b need 101", tr[3:1]);
    end
    take_rsp();
  endtask

  task automatic test_stall();
    logic rdy;
    int lat;
    logic [63:0] tr;
    alu_gnt = 1'b0;
    send(32'd6, 32'd7, rdy);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      checks++;
      if (alu_req !== 1'b1 || alu_op1 !== 32'd0 || alu_op2 !== 32'd6 || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d: req=%b op1=%h op2=%h rsp_valid=%b need 1 0 6 0",
                 n, alu_req, alu_op1, alu_op2, rsp_valid);
      end
    end
    @(posedge clk);
    #1 alu_gnt = 1'b1;
    wait_rsp(lat, tr);
    checks++;
    if (lat + 3 != 7 || rsp_data !== 32'd42) begin
      errors++;
      $display("FAIL stall_result: rsp at T+%0d data=%h need T+7 and 42", lat + 3, rsp_data);
    end
    take_rsp();
  endtask

  task automatic test_back_to_back();
    logic rdy;
    int lat;
    logic [63:0] tr;
    send(32'd6, 32'd7, rdy);
    wait_rsp(lat, tr);
    // A second request waits on the input while the response is back-pressured.
    req_valid = 1'b1;
    req_a = 32'd3;
    req_b = 32'd3;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd42 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: rsp_valid=%b data=%h req_ready=%b need 1 42 0",
                 n, rsp_valid, rsp_data, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== IDLE || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle_first: state=%0d req_ready=%b need %0d 1", dbg_state, req_ready, IDLE);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(lat, tr);
    checks++;
    if (lat != 3 || rsp_data !== 32'd9) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d data=%h need 3 9", lat, rsp_data);
    end
    take_rsp();
  endtask

  task automatic test_reset_mid();
    logic rdy;
    logic seen;
    send(32'd6, 32'd7, rdy);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== IDLE || req_ready !== 1'b1 || rsp_data !== '0) begin
      errors++;
      $display("FAIL abort_idle: state=%0d req_ready=%b data=%h need %0d 1 0",
               dbg_state, req_ready, rsp_data, IDLE);
    end
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_rsp: rsp_valid seen=%b need 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_zero_b();
    test_all_ones();
    test_negative();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle sequencer that computes the low Data_Width bits of a×b, which is RISC-V MUL and is identical for signed and unsigned operands. It runs a shift-and-add loop and borrows the shared regFileALU for every accumulate step. It sits beside the execute stage: it requests the ALU through a req/gnt pair from the external ALU arbiter and returns the product over a valid/ready response channel.

## Interface
Parameters:
- Data_Width, 32, operand, ALU and result width.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- req_valid  input  1  operand pair offered.
- req_ready  output  1  sequencer can accept; high exactly when state is IDLE.
- req_a  input  Data_Width  multiplicand.
- req_b  input  Data_Width  multiplier.
- rsp_valid  output  1  product available; high exactly when state is DONE.
- rsp_ready  input  1  consumer takes the product.
- rsp_data  output  Data_Width  product, low Data_Width bits.
- alu_req  output  1  ALU needed this cycle.
- alu_gnt  input  1  arbiter grant; meaningful only while alu_req is high.
- alu_op1  output  Data_Width  accumulator; 0 when alu_req is low.
- alu_op2  output  Data_Width  shifted multiplicand; 0 when alu_req is low.
- alu_ctrl  output  4  ALU_ADD (4'b0000) when alu_req is high, else 4'b0000.
- alu_out  input  Data_Width  ALU result; sampled only when alu_req && alu_gnt.

## Operation
- Registers:
  - acc (Data_Width)
  - mcand (Data_Width)
  - mplier (Data_Width)
  - state
- States: IDLE, STEP, DONE.
- IDLE: when req_valid is high, load acc←0, mcand←req_a, mplier←req_b, and go to STEP.
- STEP, mplier==0: go to DONE with no register change. This only happens when req_b==0.
- STEP, mplier[0]==1: alu_req=1.
  - If alu_gnt=1: acc←alu_out, mcand←mcand<<1, mplier←mplier>>1.
  - If alu_gnt=0: hold every register and stay in STEP (stall).
- STEP, mplier[0]==0 and mplier!=0: alu_req=0, mcand←mcand<<1, mplier←mplier>>1. No grant is needed.
- STEP exit: a step that advances with (mplier>>1)==0 goes directly to DONE.
- DONE: rsp_data=acc, which holds stable. When rsp_ready is high, go to IDLE.
- Arithmetic:
  - Modulo 2^Data_Width; overflow bits are discarded.
  - Shifts are logical.
  - There is no signed path; two's-complement low bits are correct for any sign mix.
- Boundary conditions:
  - alu_gnt high while alu_req is low is ignored.
  - req_valid outside IDLE is ignored; req_ready is low.
  - A new request is never accepted in the same cycle as a response handshake. IDLE is re-entered first.
  - Reset mid-operation aborts the operation. No response is ever issued for the aborted request.

## Timing
- Reset values:
  - state=IDLE, so req_ready=1 and rsp_valid=0.
  - acc, mcand, mplier and rsp_data are 0.
  - alu_req=0; alu_op1 and alu_op2 are 0; alu_ctrl=4'b0000.
- Latency: define the accept handshake in cycle T and k = index of the most-significant set bit of req_b (k=0 for req_b of 0 or 1). With no stalls, rsp_valid rises at T+k+2.
- Each cycle with alu_req=1 and alu_gnt=0 adds one cycle.
- Worst case with no stalls is 33 cycles, when req_b[Data_Width-1]=1.
- ALU path: alu_op1, alu_op2 and alu_ctrl are combinational from the registers. alu_out is captured in the same cycle the grant is seen; it is a single-cycle combinational ALU.
- rsp_valid holds until rsp_ready, and rsp_data stays stable throughout.

## Structure
- Shared package alu_pkg:
  - ALU control constants: ALU_ADD=0000, ALU_SUB=0001, ALU_AND=0010, ALU_OR=0011, ALU_SLL=0100, ALU_SLT=0101, ALU_SRL=0110, ALU_SRA=0111, ALU_BGE=1000, ALU_XOR=1001.
  - The mul_state_t enum (IDLE, STEP, DONE).
- No sub-module. The ALU instance and the arbiter stay outside; this block only drives their ports.

## Test plan
- a=6, b=7, alu_gnt tied 1, accept at T → rsp_valid at T+4, rsp_data=42; alu_req high in T+1..T+3.
- a=0x12345678, b=0 → rsp_valid at T+2, rsp_data=0, alu_req never asserted.
- a=0xFFFFFFFF, b=0xFFFFFFFF, gnt=1 → rsp_valid at T+33, rsp_data=0x00000001.
- a=0xFFFFFFFD (−3), b=5, gnt=1 → rsp_data=0xFFFFFFF1 at T+4; alu_req low at T+2 (bit 1 clear).
- a=6, b=7, alu_gnt=0 during T+1..T+3, then 1 → rsp_valid at T+7, rsp_data=42, acc unchanged while stalled.
- a=6, b=7, rsp_ready held 0 for 5 cycles → rsp_valid and rsp_data=42 stable, req_ready=0.
- Same stimulus, then rst asserted at T+2 → IDLE at T+3, no response.
